// File: rtl/core_decode_q.sv
// core_decode_q: RV32 instruction decoder feeding a small FIFO of decoded bundles.
// Each accepted instruction is classified into an enumerated op plus its
// register fields, immediate and PC. The result is queued, and the queue head
// is presented on the outputs.
// IN/OUT occupy the custom-0 opcode (0001011): func3 000 = IN, 001 = OUT.
module core_decode_q #(
    parameter int DEPTH     = 2,
    parameter int ENABLE_F  = 1,
    parameter int ENABLE_IO = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INST,
    input  logic [31:0] PC,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [5:0]  OP,
    output logic        ILLEGAL,
    output logic [4:0]  RD_NUM,
    output logic [4:0]  RS1_NUM,
    output logic [4:0]  RS2_NUM,
    output logic [31:0] IMM,
    output logic [31:0] PC_OUT,
    output logic [3:0]  COUNT
);

    localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int BW = 86;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_IO
    } fmt_t;

    logic [6:0]    w_opc;
    logic [2:0]    w_f3;
    logic [6:0]    w_f7;
    logic [5:0]    w_op;
    fmt_t          w_fmt;
    logic [4:0]    w_rd;
    logic [4:0]    w_rs1;
    logic [4:0]    w_rs2;
    logic [31:0]   w_imm;
    logic [BW-1:0] w_bundle;
    logic [BW-1:0] w_head;
    logic [BW-1:0] w_slot [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic [PW-1:0] w_wr_ptr_next;
    logic [PW-1:0] w_rd_ptr_next;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;

    assign w_opc = INST[6:0];
    assign w_f3  = INST[14:12];
    assign w_f7  = INST[31:25];

    // Classify the incoming word into an op number and its operand format
    always_comb begin
        w_op  = 6'd0;
        w_fmt = FMT_NONE;
        case (w_opc)
            7'b0010011: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000:  w_op = 6'd1;
                    3'b010:  w_op = 6'd2;
                    3'b011:  w_op = 6'd3;
                    3'b100:  w_op = 6'd4;
                    3'b110:  w_op = 6'd5;
                    3'b111:  w_op = 6'd6;
                    3'b001:  if (w_f7 == 7'b0000000) w_op = 6'd7;
                    3'b101: begin
                        if (w_f7 == 7'b0000000)      w_op = 6'd8;
                        else if (w_f7 == 7'b0100000) w_op = 6'd9;
                    end
                    default: ;
                endcase
            end
            7'b0110011: begin
                w_fmt = FMT_R;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_op = 6'd10;
                        3'b001:  w_op = 6'd12;
                        3'b010:  w_op = 6'd13;
                        3'b011:  w_op = 6'd14;
                        3'b100:  w_op = 6'd15;
                        3'b101:  w_op = 6'd16;
                        3'b110:  w_op = 6'd18;
                        3'b111:  w_op = 6'd19;
                        default: ;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    case (w_f3)
                        3'b000:  w_op = 6'd11;
                        3'b101:  w_op = 6'd17;
                        default: ;
                    endcase
                end
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'b000:  w_op = 6'd20;
                    3'b001:  w_op = 6'd21;
                    3'b100:  w_op = 6'd22;
                    3'b101:  w_op = 6'd23;
                    3'b110:  w_op = 6'd24;
                    3'b111:  w_op = 6'd25;
                    default: ;
                endcase
            end
            7'b0000011: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000:  w_op = 6'd26;
                    3'b001:  w_op = 6'd27;
                    3'b010:  w_op = 6'd28;
                    3'b100:  w_op = 6'd29;
                    3'b101:  w_op = 6'd30;
                    default: ;
                endcase
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                case (w_f3)
                    3'b000:  w_op = 6'd31;
                    3'b001:  w_op = 6'd32;
                    3'b010:  w_op = 6'd33;
                    default: ;
                endcase
            end
            7'b1100111: begin
                w_fmt = FMT_I;
                if (w_f3 == 3'b000) w_op = 6'd34;
            end
            7'b1101111: begin
                w_fmt = FMT_J;
                w_op  = 6'd35;
            end
            7'b0010111: begin
                w_fmt = FMT_U;
                w_op  = 6'd36;
            end
            7'b0110111: begin
                w_fmt = FMT_U;
                w_op  = 6'd37;
            end
            7'b0000111: begin
                w_fmt = FMT_I;
                if (ENABLE_F != 0 && w_f3 == 3'b010) w_op = 6'd38;
            end
            7'b0100111: begin
                w_fmt = FMT_S;
                if (ENABLE_F != 0 && w_f3 == 3'b010) w_op = 6'd39;
            end
            7'b1010011: begin
                w_fmt = FMT_R;
                if (ENABLE_F != 0) begin
                    case (w_f7)
                        7'b0000000: w_op = 6'd40;
                        7'b0000100: w_op = 6'd41;
                        7'b0001000: w_op = 6'd42;
                        7'b0001100: w_op = 6'd43;
                        7'b1010000: begin
                            case (w_f3)
                                3'b010:  w_op = 6'd44;
                                3'b001:  w_op = 6'd45;
                                3'b000:  w_op = 6'd46;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            7'b0001011: begin
                w_fmt = FMT_IO;
                if (ENABLE_IO != 0) begin
                    case (w_f3)
                        3'b000:  w_op = 6'd47;
                        3'b001:  w_op = 6'd48;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        // Illegal words carry no operands at all
        if (w_op == 6'd0) w_fmt = FMT_NONE;
    end

    // Extract register numbers and the sign-extended immediate for the format
    always_comb begin
        w_rd  = 5'd0;
        w_rs1 = 5'd0;
        w_rs2 = 5'd0;
        w_imm = 32'd0;
        case (w_fmt)
            FMT_R: begin
                w_rd  = INST[11:7];
                w_rs1 = INST[19:15];
                w_rs2 = INST[24:20];
            end
            FMT_I: begin
                w_rd  = INST[11:7];
                w_rs1 = INST[19:15];
                w_imm = {{20{INST[31]}}, INST[31:20]};
            end
            FMT_S: begin
                w_rs1 = INST[19:15];
                w_rs2 = INST[24:20];
                w_imm = {{20{INST[31]}}, INST[31:25], INST[11:7]};
            end
            FMT_B: begin
                w_rs1 = INST[19:15];
                w_rs2 = INST[24:20];
                w_imm = {{19{INST[31]}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
            end
            FMT_U: begin
                w_rd  = INST[11:7];
                w_imm = {INST[31:12], 12'h000};
            end
            FMT_J: begin
                w_rd  = INST[11:7];
                w_imm = {{11{INST[31]}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
            end
            FMT_IO: begin
                w_rd  = INST[11:7];
            end
            default: ;
        endcase
    end

    assign w_bundle = {w_op, (w_op == 6'd0), w_rd, w_rs1, w_rs2, w_imm, PC};

    // Full queue never accepts, even if the head leaves in the same cycle
    assign w_in_ready    = !RST && !FLUSH && (r_count < 4'(DEPTH));
    assign w_push        = IN_VALID && w_in_ready;
    assign w_pop         = (r_count != 4'd0) && OUT_READY && !FLUSH && !RST;
    assign w_wr_ptr_next = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [BW-1:0] r_entry;
        // Capture the decoded bundle when this slot is the tail
        always_ff @(posedge CLK) begin
            if (w_push && (r_wr_ptr == PW'(gi))) begin
                r_entry <= w_bundle;
            end
        end
        assign w_slot[gi] = r_entry;
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_next;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: ;
            endcase
        end
    end

    // Empty queue presents an all-zero head
    assign w_head    = (r_count != 4'd0) ? w_slot[r_rd_ptr] : '0;
    assign IN_READY  = w_in_ready;
    assign OUT_VALID = (r_count != 4'd0);
    assign COUNT     = r_count;
    assign {OP, ILLEGAL, RD_NUM, RS1_NUM, RS2_NUM, IMM, PC_OUT} = w_head;

endmodule
